mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the combinational ALU in the EX stage. Executes mult/multu/div/divu/mthi/mtlo over multiple cycles.
- The pipeline stalls HI/LO readers and new MDU ops while busy is high.
- Generalises the ALU's operand width to WIDTH and adds sequential, handshaked operation.

---
 rtl/mdu_iter.sv | 177 +++++++++++++++++
 tb/tb_mdu_iter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply, restoring divide.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu accumulation into {hi,lo}.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e            state;
  logic [CntW-1:0]   cnt;
  logic [WIDTH-1:0]  opb;
  logic [WIDTH-1:0]  p_hi;
  logic [WIDTH-1:0]  p_lo;
  logic              is_div;
  logic              neg_p;
  logic              neg_q;
  logic              neg_r;
  logic              div0;
`ifdef MDU_MADD_EN
  logic [1:0]        acc_mode;
`endif

  // Opcode decode for the iterative (mult/div class) ops.
  logic       dec_iter;
  logic       dec_div;
  logic       dec_sgn;
  logic [1:0] dec_acc;

  always_comb begin
    dec_iter = 1'b1;
    dec_div  = 1'b0;
    dec_sgn  = 1'b0;
    dec_acc  = 2'd0;
    case (op)
      4'd1: dec_sgn = 1'b1;
      4'd2: dec_sgn = 1'b0;
      4'd3: begin dec_div = 1'b1; dec_sgn = 1'b1; end
      4'd4: dec_div = 1'b1;
`ifdef MDU_MADD_EN
      4'd7:  begin dec_sgn = 1'b1; dec_acc = 2'd1; end
      4'd8:  dec_acc = 2'd1;
      4'd9:  begin dec_sgn = 1'b1; dec_acc = 2'd2; end
      4'd10: dec_acc = 2'd2;
`endif
      default: dec_iter = 1'b0;
    endcase
  end

  logic             sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign sa    = dec_sgn & a[WIDTH-1];
  assign sb    = dec_sgn & b[WIDTH-1];
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;

  // One iteration of each algorithm.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;

  assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
  assign div_shift = {p_hi, p_lo[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opb};
  assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opb) : div_shift[WIDTH-1:0];

  // Sign correction and optional accumulation applied in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_p ? -{p_hi, p_lo} : {p_hi, p_lo};
    mul_res  = prod_fix;
`ifdef MDU_MADD_EN
    if (acc_mode == 2'd1) begin
      mul_res = {hi, lo} + prod_fix;
    end else if (acc_mode == 2'd2) begin
      mul_res = {hi, lo} - prod_fix;
    end
`endif
    // Divide-by-zero keeps the raw all-ones quotient.
    quo_fix = (neg_q && !div0) ? -p_lo : p_lo;
    rem_fix = neg_r ? -p_hi : p_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      cnt      <= '0;
      opb      <= '0;
      p_hi     <= '0;
      p_lo     <= '0;
      is_div   <= 1'b0;
      neg_p    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
`ifdef MDU_MADD_EN
      acc_mode <= 2'd0;
`endif
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            if (op == 4'd5) begin
              hi <= a;
            end else if (op == 4'd6) begin
              lo <= a;
            end else if (dec_iter) begin
              state    <= StRun;
              busy     <= 1'b1;
              cnt      <= '0;
              opb      <= abs_b;
              p_hi     <= '0;
              p_lo     <= abs_a;
              is_div   <= dec_div;
              neg_p    <= sa ^ sb;
              neg_q    <= sa ^ sb;
              neg_r    <= sa;
              div0     <= (b == '0);
`ifdef MDU_MADD_EN
              acc_mode <= dec_acc;
`endif
            end
          end
        end
        StRun: begin
          if (is_div) begin
            p_hi <= div_rem;
            p_lo <= {p_lo[WIDTH-2:0], div_ge};
          end else begin
            {p_hi, p_lo} <= {mul_sum, p_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CntLast) begin
            state <= StFix;
          end
        end
        StFix: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= mul_res;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (WIDTH=32).
module tb_mdu_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_chk = 0;
  int n_fail = 0;

  mdu_iter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op at a negedge and follow it to completion. When poke is set, a
  // second start is raised mid-operation and must be ignored.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int exp_cyc, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input bit poke);
    int n;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    op    = 4'd0;
    if (exp_cyc > 0) check({tag, "_busy_up"}, {63'd0, busy}, 64'd1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      a = ~a;
      b = b + 32'h1111_1111;
      if (poke && n == 5) begin
        start = 1'b1;
        op    = 4'd2;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
      end else begin
        start = 1'b0;
        op    = 4'd0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
    check({tag, "_done"}, {63'd0, done}, (exp_cyc > 0) ? 64'd1 : 64'd0);
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
  endtask

  initial begin
    bit seen_done;
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'h0000_0003, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'h0000_0003, 33, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu0", 4'd4, 32'h0000_0007, 32'h0000_0000, 33, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0);
    run_op("divmin", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divs0", 4'd3, 32'hFFFF_FFF9, 32'h0000_0000, 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
    run_op("divu", 4'd4, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);
    // Back-to-back: issued in the done cycle of divu.
    run_op("b2b_poke", 4'd1, 32'd3, 32'd5, 33, 32'd0, 32'd15, 1'b1);
    run_op("mthi", 4'd5, 32'h1234_5678, 32'd0, 0, 32'h1234_5678, 32'd15, 1'b0);
    run_op("mtlo", 4'd6, 32'hCAFE_F00D, 32'd0, 0, 32'h1234_5678, 32'hCAFE_F00D, 1'b0);
    run_op("nop", 4'd15, 32'hDEAD_BEEF, 32'd1, 0, 32'h1234_5678, 32'hCAFE_F00D, 1'b0);

    run_op("pre_hi", 4'd5, 32'h0000_0000, 32'd0, 0, 32'h0000_0000, 32'hCAFE_F00D, 1'b0);
    run_op("pre_lo", 4'd6, 32'hFFFF_FFFF, 32'd0, 0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
`ifdef MDU_MADD_EN
    run_op("madd", 4'd7, 32'd1, 32'd1, 33, 32'h0000_0001, 32'h0000_0000, 1'b0);
    run_op("msubu", 4'd10, 32'd2, 32'd3, 33, 32'h0000_0000, 32'hFFFF_FFFA, 1'b0);
`else
    run_op("madd_off", 4'd7, 32'd1, 32'd1, 0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
`endif

    // Abort a multiply once the iteration counter has reached 10.
    start = 1'b1;
    op    = 4'd1;
    a     = 32'd1000;
    b     = 32'd1000;
    @(negedge clk);
    start = 1'b0;
    op    = 4'd0;
    repeat (10) @(negedge clk);
    check("abort_cnt", 64'(dut.cnt), 64'd10);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen_done |= done;
    end
    check("abort_nodone", {63'd0, seen_done}, 64'd0);
    check("abort_hilo_after", {hi, lo}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
